// File: rtl/pipe_alu_if.sv
// pipe_alu_if: issue and result handshake bundle for pipe_alu.
//   Issue side : in_valid/in_ready handshake carrying op_in, r1_val, r2_val
//                and rob_id_in (destination tag).
//   Result side: out_valid/out_ready handshake carrying out_val and
//                out_rob_id towards the common data bus.
//   master - the issuing / consuming agent (scheduler + CDB arbiter).
//   slave  - the ALU itself.
interface pipe_alu_if #(
  parameter int XLEN    = 32,
  parameter int ROB_BIT = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         op_in;
  logic [XLEN-1:0]    r1_val;
  logic [XLEN-1:0]    r2_val;
  logic [ROB_BIT-1:0] rob_id_in;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_val;
  logic [ROB_BIT-1:0] out_rob_id;

  modport master (
    output in_valid, op_in, r1_val, r2_val, rob_id_in, out_ready,
    input  in_ready, out_valid, out_val, out_rob_id
  );

  modport slave (
    input  in_valid, op_in, r1_val, r2_val, rob_id_in, out_ready,
    output in_ready, out_valid, out_val, out_rob_id
  );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu: pipelined integer ALU (RV32I ALU ops, branch compares, RV32M
// multiplies) with a credit-controlled in-order output buffer.
//   clk_in   - clock, all state changes on the rising edge
//   rst_in   - asynchronous active-low reset
//   rdy_in   - global stall, low freezes every register
//   flush_in - synchronous mispredict clear, dominant over all other inputs
//   bus      - pipe_alu_if.slave: issue handshake in, result handshake out
// The result is computed in stage 1; stages 2..PIPE_DEPTH only delay it.
// An entry leaving the last stage is written into the output buffer. Credits
// count in-flight plus buffered entries so the buffer can never overflow and
// the pipeline never has to stall on out_ready.
module pipe_alu #(
  parameter int XLEN       = 32,
  parameter int ROB_BIT    = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int OUT_DEPTH  = 4,
  parameter int HAS_MUL    = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  pipe_alu_if.slave   bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int PW  = $clog2(OUT_DEPTH);
  localparam int CW  = PW + 1;

  // pipeline stages
  logic [PIPE_DEPTH-1:0] r_stg_vld;
  logic [XLEN-1:0]       r_stg_val [PIPE_DEPTH];
  logic [ROB_BIT-1:0]    r_stg_tag [PIPE_DEPTH];
  // output buffer
  logic [XLEN-1:0]       r_buf_val [OUT_DEPTH];
  logic [ROB_BIT-1:0]    r_buf_tag [OUT_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_buf_cnt;
  logic [CW-1:0]         r_tot_cnt;
  logic                  r_in_ready;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         w_tot_next;
  logic [XLEN-1:0]       w_a;
  logic [XLEN-1:0]       w_b;
  logic [SHW-1:0]        w_shamt;
  logic                  w_lt;
  logic                  w_ltu;
  logic                  w_eq;
  logic                  w_a_sgn;
  logic                  w_b_sgn;
  logic [2*XLEN-1:0]     w_ma;
  logic [2*XLEN-1:0]     w_mb;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_alu;

  assign w_a     = bus.r1_val;
  assign w_b     = bus.r2_val;
  assign w_shamt = w_b[SHW-1:0];
  assign w_lt    = $signed(w_a) < $signed(w_b);
  assign w_ltu   = w_a < w_b;
  assign w_eq    = w_a == w_b;

  // One 2*XLEN multiplier serves all four MUL variants: operands are sign- or
  // zero-extended per op, and the low 2*XLEN bits of the product are exact.
  assign w_a_sgn = (bus.op_in == 5'd17) || (bus.op_in == 5'd18);
  assign w_b_sgn = (bus.op_in == 5'd17);
  assign w_ma    = {{XLEN{w_a_sgn & w_a[XLEN-1]}}, w_a};
  assign w_mb    = {{XLEN{w_b_sgn & w_b[XLEN-1]}}, w_b};
  assign w_prod  = w_ma * w_mb;

  assign w_accept   = bus.in_valid & r_in_ready & rdy_in & ~flush_in;
  assign w_pop      = (r_buf_cnt != {CW{1'b0}}) & bus.out_ready & rdy_in & ~flush_in;
  assign w_push     = r_stg_vld[PIPE_DEPTH-1];
  assign w_tot_next = r_tot_cnt + CW'(w_accept) - CW'(w_pop);

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = (r_buf_cnt != {CW{1'b0}});
  assign bus.out_val    = r_buf_val[r_rd_ptr];
  assign bus.out_rob_id = r_buf_tag[r_rd_ptr];

  // Stage-1 result decode for every opcode.
  always_comb begin
    w_alu = {XLEN{1'b0}};
    case (bus.op_in)
      5'd0:    w_alu = w_a + w_b;
      5'd1:    w_alu = w_a - w_b;
      5'd2:    w_alu = w_a << w_shamt;
      5'd3:    w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd4:    w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd5:    w_alu = w_a ^ w_b;
      5'd6:    w_alu = w_a >> w_shamt;
      5'd7:    w_alu = $signed(w_a) >>> w_shamt;
      5'd8:    w_alu = w_a | w_b;
      5'd9:    w_alu = w_a & w_b;
      5'd10:   w_alu = {{(XLEN-1){1'b0}}, w_eq};
      5'd11:   w_alu = {{(XLEN-1){1'b0}}, ~w_eq};
      5'd12:   w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd13:   w_alu = {{(XLEN-1){1'b0}}, ~w_lt};
      5'd14:   w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd15:   w_alu = {{(XLEN-1){1'b0}}, ~w_ltu};
      5'd16:   w_alu = (HAS_MUL != 0) ? w_prod[XLEN-1:0] : {XLEN{1'b0}};
      5'd17,
      5'd18,
      5'd19:   w_alu = (HAS_MUL != 0) ? w_prod[2*XLEN-1:XLEN] : {XLEN{1'b0}};
      default: w_alu = {XLEN{1'b0}};
    endcase
  end

  // Pipeline stages: load stage 1 on every advancing edge, shift the rest.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stg_vld <= {PIPE_DEPTH{1'b0}};
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_stg_val[i] <= {XLEN{1'b0}};
        r_stg_tag[i] <= {ROB_BIT{1'b0}};
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_stg_vld <= {PIPE_DEPTH{1'b0}};
      end else begin
        r_stg_vld[0] <= w_accept;
        r_stg_val[0] <= w_alu;
        r_stg_tag[0] <= bus.rob_id_in;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          r_stg_vld[i] <= r_stg_vld[i-1];
          r_stg_val[i] <= r_stg_val[i-1];
          r_stg_tag[i] <= r_stg_tag[i-1];
        end
      end
    end
  end

  // Output buffer storage and wrapping pointers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_buf_val[i] <= {XLEN{1'b0}};
        r_buf_tag[i] <= {ROB_BIT{1'b0}};
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
        for (int i = 0; i < OUT_DEPTH; i++) begin
          r_buf_val[i] <= {XLEN{1'b0}};
          r_buf_tag[i] <= {ROB_BIT{1'b0}};
        end
      end else begin
        if (w_push) begin
          r_buf_val[r_wr_ptr] <= r_stg_val[PIPE_DEPTH-1];
          r_buf_tag[r_wr_ptr] <= r_stg_tag[PIPE_DEPTH-1];
          r_wr_ptr            <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end
  end

  // Occupancy and credit tracking; in_ready is registered from the next total
  // so it rises on the first edge after reset and never looks at in_valid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_buf_cnt  <= {CW{1'b0}};
      r_tot_cnt  <= {CW{1'b0}};
      r_in_ready <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_buf_cnt  <= {CW{1'b0}};
        r_tot_cnt  <= {CW{1'b0}};
        r_in_ready <= 1'b1;
      end else begin
        r_buf_cnt  <= r_buf_cnt + CW'(w_push) - CW'(w_pop);
        r_tot_cnt  <= w_tot_next;
        r_in_ready <= (w_tot_next < CW'(OUT_DEPTH));
      end
    end
  end
endmodule
